// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU: opcode and FSM state encodings,
// plus helpers that locate instruction fields from the configured widths.
package cpu_pkg;

    localparam int OPCODE_WIDTH = 6;

    typedef enum logic [5:0] {
        OP_ADD        = 6'd0,
        OP_INC        = 6'd1,
        OP_DECREMENT  = 6'd2,
        OP_LSHIFT     = 6'd3,
        OP_RSHIFT     = 6'd4,
        OP_LOAD       = 6'd5,
        OP_LOADSWITCH = 6'd6,
        OP_JUMP       = 6'd7,
        OP_JUMPZ      = 6'd8,
        OP_JUMPREG    = 6'd9,
        OP_LD         = 6'd10,
        OP_ST         = 6'd11,
        OP_HALT       = 6'd12,
        OP_RESET      = 6'd13
    } opcode_e;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_EXECUTE = 2'd1,
        S_MEM     = 2'd2,
        S_HALT    = 2'd3
    } state_e;

    // Fields are packed MSB-first: opCode, rd, rs1, rs2, ind, imm.
    function automatic int rd_lsb(input int iw, input int ri);
        return iw - OPCODE_WIDTH - ri;
    endfunction

    function automatic int rs1_lsb(input int iw, input int ri);
        return iw - OPCODE_WIDTH - 2 * ri;
    endfunction

    function automatic int rs2_lsb(input int iw, input int ri);
        return iw - OPCODE_WIDTH - 3 * ri;
    endfunction

    function automatic int ind_pos(input int iw, input int ri);
        return iw - OPCODE_WIDTH - 3 * ri - 1;
    endfunction

    function automatic int imm_lsb(input int iw, input int ri, input int rw);
        return iw - OPCODE_WIDTH - 3 * ri - 1 - rw;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational datapath for the register-writing opcodes; results wrap
// modulo 2^REGISTER_WIDTH.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int REGISTER_WIDTH = 8
) (
    input  opcode_e                   op_i,
    input  logic [REGISTER_WIDTH-1:0] rs1_i,
    input  logic [REGISTER_WIDTH-1:0] rs2_i,
    input  logic [REGISTER_WIDTH-1:0] imm_i,
    input  logic                      switch_i,
    output logic [REGISTER_WIDTH-1:0] result_o,
    output logic                      wr_en_o
);

    // Result select; opcodes outside this set never write a register.
    always_comb begin
        result_o = {REGISTER_WIDTH{1'b0}};
        wr_en_o  = 1'b1;
        case (op_i)
            OP_ADD:        result_o = rs1_i + rs2_i;
            OP_INC:        result_o = rs1_i + REGISTER_WIDTH'(1);
            OP_DECREMENT:  result_o = rs1_i - REGISTER_WIDTH'(1);
            OP_LSHIFT:     result_o = rs1_i << 1;
            OP_RSHIFT:     result_o = rs1_i >> 1;
            OP_LOAD:       result_o = imm_i;
            OP_LOADSWITCH: result_o = {{(REGISTER_WIDTH-1){1'b0}}, switch_i};
            default:       wr_en_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle CPU: FETCH/EXECUTE/MEM/HALT controller, register file and pc.
// Define CPU_INDIRECT_EN to let ind=1 take the LD/ST address and JUMP/JUMPZ target from rs2.
// ST stores the value of rs1.
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter int REGISTER_WIDTH      = 8,
    parameter int NUMBER_OF_REGISTERS = 8,
    parameter int PC_WIDTH            = 8,
    parameter int INSTRUCTION_WIDTH   = 24
) (
    input  logic                         clock,
    input  logic                         isReset,
    input  logic                         switch,
    output logic                         imemReq,
    output logic [PC_WIDTH-1:0]          imemAddr,
    input  logic                         imemValid,
    input  logic [INSTRUCTION_WIDTH-1:0] imemData,
    output logic                         dmemReq,
    output logic                         dmemWe,
    output logic [REGISTER_WIDTH-1:0]    dmemAddr,
    output logic [REGISTER_WIDTH-1:0]    dmemWdata,
    input  logic                         dmemAck,
    input  logic [REGISTER_WIDTH-1:0]    dmemRdata,
    output logic [PC_WIDTH-1:0]          pc,
    output logic [REGISTER_WIDTH-1:0]    register1Value,
    output logic                         halted
);

    localparam int RI       = $clog2(NUMBER_OF_REGISTERS);
    localparam int IW       = INSTRUCTION_WIDTH;
    localparam int RW       = REGISTER_WIDTH;
    localparam int RD_LSB   = rd_lsb(IW, RI);
    localparam int RS1_LSB  = rs1_lsb(IW, RI);
    localparam int RS2_LSB  = rs2_lsb(IW, RI);
    localparam int IND_POS  = ind_pos(IW, RI);
    localparam int IMM_LSB  = imm_lsb(IW, RI, RW);

    state_e          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc_s;
    logic [IW-1:0]   instr_q, instr_d;
    logic [RW-1:0]   regs_q [NUMBER_OF_REGISTERS];
    logic [RW-1:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic            mem_we_q, mem_we_d;
    logic            reg_we_s, reset_s, alu_wr_s;
    logic [RW-1:0]   reg_wdata_s, alu_result_s, rs1_val_s, rs2_val_s, imm_s, target_s;
    logic [RI-1:0]   rd_s, rs1_s, rs2_s;
    opcode_e         op_s;

    assign op_s      = opcode_e'(instr_q[IW-1 -: OPCODE_WIDTH]);
    assign rd_s      = instr_q[RD_LSB +: RI];
    assign rs1_s     = instr_q[RS1_LSB +: RI];
    assign rs2_s     = instr_q[RS2_LSB +: RI];
    assign imm_s     = instr_q[IMM_LSB +: RW];
    assign rs1_val_s = (rs1_s == {RI{1'b0}}) ? {RW{1'b0}} : regs_q[rs1_s];
    assign rs2_val_s = (rs2_s == {RI{1'b0}}) ? {RW{1'b0}} : regs_q[rs2_s];
    assign pc_inc_s  = pc_q + PC_WIDTH'(1);

`ifdef CPU_INDIRECT_EN
    assign target_s = instr_q[IND_POS] ? rs2_val_s : imm_s;
`else
    logic unused_ind_s;
    assign unused_ind_s = instr_q[IND_POS];
    assign target_s     = imm_s;
`endif

    // The RESET opcode clears state exactly like the external reset.
    assign reset_s = isReset || ((state_q == S_EXECUTE) && (op_s == OP_RESET));

    assign imemReq        = (state_q == S_FETCH) && !isReset;
    assign imemAddr       = pc_q;
    assign dmemReq        = (state_q == S_MEM) && !isReset;
    assign dmemWe         = mem_we_q;
    assign dmemAddr       = mem_addr_q;
    assign dmemWdata      = mem_wdata_q;
    assign pc             = pc_q;
    assign register1Value = rs1_val_s;
    assign halted         = (state_q == S_HALT);

    cpu_alu #(.REGISTER_WIDTH(RW)) u_alu (
        .op_i     (op_s),
        .rs1_i    (rs1_val_s),
        .rs2_i    (rs2_val_s),
        .imm_i    (imm_s),
        .switch_i (switch),
        .result_o (alu_result_s),
        .wr_en_o  (alu_wr_s)
    );

    // Next-state, pc, memory request and register write-back decode.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        reg_we_s    = 1'b0;
        reg_wdata_s = {RW{1'b0}};
        case (state_q)
            S_FETCH: begin
                if (imemValid) begin
                    instr_d = imemData;
                    state_d = S_EXECUTE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                pc_d    = pc_inc_s;
                case (op_s)
                    OP_JUMP:    pc_d = PC_WIDTH'(target_s);
                    OP_JUMPZ:   pc_d = (rs1_val_s == {RW{1'b0}}) ? PC_WIDTH'(target_s) : pc_inc_s;
                    OP_JUMPREG: pc_d = PC_WIDTH'(rs1_val_s);
                    OP_LD, OP_ST: begin
                        pc_d        = pc_q;
                        state_d     = S_MEM;
                        mem_addr_d  = target_s;
                        mem_we_d    = (op_s == OP_ST);
                        mem_wdata_d = rs1_val_s;
                    end
                    OP_HALT: begin
                        pc_d    = pc_q;
                        state_d = S_HALT;
                    end
                    default: begin
                        reg_we_s    = alu_wr_s;
                        reg_wdata_s = alu_result_s;
                    end
                endcase
            end
            S_MEM: begin
                if (dmemAck) begin
                    state_d = S_FETCH;
                    pc_d    = pc_inc_s;
                    if (!mem_we_q) begin
                        reg_we_s    = 1'b1;
                        reg_wdata_s = dmemRdata;
                    end else begin
                        reg_we_s    = 1'b0;
                    end
                end else begin
                    state_d = S_MEM;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // State, pc, held instruction, memory request and register file.
    always_ff @(posedge clock) begin
        if (reset_s) begin
            state_q     <= S_FETCH;
            pc_q        <= {PC_WIDTH{1'b0}};
            instr_q     <= {IW{1'b0}};
            mem_addr_q  <= {RW{1'b0}};
            mem_we_q    <= 1'b0;
            mem_wdata_q <= {RW{1'b0}};
            for (int i = 0; i < NUMBER_OF_REGISTERS; i++) begin
                regs_q[i] <= {RW{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            if (reg_we_s && (rd_s != {RI{1'b0}})) begin
                regs_q[rd_s] <= reg_wdata_s;
            end
        end
    end

endmodule

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 Parameter REGISTER_WIDTH, default 8, width of every register, ALU path and data-memory word.
REQ-002 Parameter NUMBER_OF_REGISTERS, default 8, power of two >= 4; register index width RI = log2(NUMBER_OF_REGISTERS).
REQ-003 Parameter PC_WIDTH, default 8, width of program counter and instruction address.
REQ-004 Parameter INSTRUCTION_WIDTH, default 24; fields MSB-first: opCode[5:0], rd[RI], rs1[RI], rs2[RI], ind[1], imm[REGISTER_WIDTH]; unused LSBs zero.
REQ-005 clock  in  1  single system clock, all state on rising edge.
REQ-006 isReset  in  1  reset, synchronous and active-high.
REQ-007 switch  in  1  board switch, read by LOADSWITCH.
REQ-008 imemReq/imemAddr  out  1/PC_WIDTH  fetch request; imemAddr = pc while imemReq high.
REQ-009 imemValid/imemData  in  1/INSTRUCTION_WIDTH  fetch response; data sampled on the cycle imemValid is high.
REQ-010 dmemReq/dmemWe/dmemAddr/dmemWdata  out  1/1/REGISTER_WIDTH/REGISTER_WIDTH  data-memory request; held stable until dmemAck.
REQ-011 dmemAck/dmemRdata  in  1/REGISTER_WIDTH  data-memory completion; rdata sampled on the ack cycle.
REQ-012 pc  out  PC_WIDTH  current program counter.
REQ-013 register1Value  out  REGISTER_WIDTH  value of register rs1 of the held instruction.
REQ-014 halted  out  1  high while in HALT state.

Function
REQ-015 FSM states FETCH, EXECUTE, MEM, HALT; one instruction retires per visit to EXECUTE (non-memory) or MEM (memory op).
REQ-016 FETCH: imemReq=1; stays until imemValid; then latches instruction, goes EXECUTE.
REQ-017 EXECUTE (one cycle): ADD rd=rs1+rs2; INC rd=rs1+1; DECREMENT rd=rs1-1; LSHIFT rd=rs1<<1; RSHIFT rd=rs1>>1 (logical); LOAD rd=imm; LOADSWITCH rd={0..,switch}; all modulo 2^REGISTER_WIDTH, carry discarded.
REQ-018 JUMP pc=imm[PC_WIDTH-1:0]; JUMPZ pc=imm if rs1==0 else pc+1; JUMPREG pc=rs1 truncated/zero-extended to PC_WIDTH; all other opcodes pc=pc+1, wrapping at 2^PC_WIDTH-1 -> 0.
REQ-019 LD/ST: EXECUTE drives dmemReq with address imm (or per REQ-028), goes MEM; MEM holds request until dmemAck, then LD writes rd=dmemRdata, ST writes nothing, pc=pc+1, go FETCH.
REQ-020 HALT opcode: enter HALT, pc frozen, no requests; only isReset leaves HALT.
REQ-021 RESET opcode: same effect as isReset asserted for one cycle.
REQ-022 Undefined opcode: no register/memory write, pc=pc+1.
REQ-023 Register 0 reads as 0 always; writes to rd=0 are discarded.
REQ-024 Register write and pc update occur on the same edge as leaving EXECUTE or MEM; at most one register write per instruction.
REQ-025 dmemReq and imemReq never both high.

Reset
REQ-026 isReset high at a rising edge, in any state including mid-fetch or mid-MEM: state=FETCH, pc=0, all registers=0, imemReq=0 and dmemReq=0 for that cycle, halted=0; pending ack/valid ignored.
REQ-027 First fetch request issued on the cycle after isReset deasserts.

Configuration
REQ-028 Macro CPU_INDIRECT_EN: when defined, ind=1 replaces imm by rs2 as LD/ST address and JUMP/JUMPZ target; when undefined, ind is ignored and imm is always used.

Structure
REQ-029 Shared package cpu_pkg holds opcode enum (ADD, INC, DECREMENT, LSHIFT, RSHIFT, LOAD, LOADSWITCH, JUMP, JUMPZ, JUMPREG, LD, ST, HALT, RESET), FSM state enum and field-offset constants.
REQ-030 One sub-module cpu_alu: combinational, opCode/operands/imm/switch in, result out; FSM, register file and pc stay in multicycle_cpu.

Verification
REQ-031 Reset then LOAD r1,5; INC r1 with imemValid one cycle after req -> r1=6, pc=2 after 4 instruction cycles.
REQ-032 imemValid delayed 3 cycles -> FSM stays FETCH, imemAddr stable, no register change until valid.
REQ-033 LD r2,0x10 with dmemAck after 2 cycles, dmemRdata=0xA5 -> dmemReq held 2 cycles, r2=0xA5; ST r2,0x11 -> dmemWe=1, dmemWdata=0xA5.
REQ-034 LOAD r1,0xFF; INC r1 -> r1=0x00; JUMPZ r1 to 0x20 -> pc=0x20; JUMP 0xFF then non-jump -> pc wraps to 0.
REQ-035 isReset asserted during MEM with ack arriving same cycle -> no write to rd, pc=0, state FETCH.
REQ-036 With CPU_INDIRECT_EN: r2=0x30, LD ind=1 -> dmemAddr=0x30; without it -> dmemAddr=imm; HALT -> halted=1, no requests until isReset.
